sha_msg_packer: RTL and testbench
=================================

// Module: sha_msg_packer
// PURPOSE
//  Upstream stage of output_data_handler: receives message bytes from uart_rx and
//  assembles one SHA-256 block (message, 0x80, zero fill, 64-bit bit length).
//  Presents the block on o_data and pulses o_sha_start. Holds the block until the
//  hash/UART-send stage reports done, then accepts the next message.
// PARAMETERS
//  MAX_BYTES     55     max message bytes per block (1..55); reaching it auto-finalizes
//  TERM_BYTE     8'h0D  end-of-message byte; never stored in the block
//  IDLE_TIMEOUT  0      cycles with no byte (count>=1) before auto-finalize; 0 = disabled
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous reset, active-high
//  i_rx_dv      in   1    1-cycle strobe, i_rx_byte valid (from uart_rx)
//  i_rx_byte    in   8    received byte
//  i_out_done   in   1    done level from downstream handler
//  o_data       out  512  padded block, big-endian: byte i at [511-8*i -: 8]
//  o_sha_start  out  1    1-cycle pulse, o_data valid and stable
//  o_busy       out  1    high in PAD, START, WAIT
//  o_len        out  6    byte count of current/last message
//  o_drop       out  1    1-cycle pulse when a byte is discarded
// BEHAVIOUR
//  Reset (sync): state=IDLE; o_data=0, o_len=0, o_sha_start=0, o_busy=0, o_drop=0;
//   timeout counter=0, done-edge register=0.
//  FSM: IDLE, COLLECT, PAD, START, WAIT.
//  IDLE: dv with byte!=TERM_BYTE -> store at index 0, o_len=1, -> COLLECT.
//   dv with TERM_BYTE -> ignored (empty message not hashed), no drop.
//  COLLECT: dv, byte!=TERM_BYTE -> store at index o_len, o_len++, timer=0.
//   Byte making o_len==MAX_BYTES -> PAD. dv with TERM_BYTE -> PAD.
//   IDLE_TIMEOUT>0: timer++ each cycle without dv; timer==IDLE_TIMEOUT-1 with no
//   dv -> PAD. dv in the expiry cycle wins: byte stored, timer=0, stay.
//  PAD (1 cycle): o_data[511-8*o_len -: 8]=8'h80; o_data[63:0]=o_len*8
//   (zero-extended); -> START.
//  START (1 cycle): o_sha_start=1; -> WAIT.
//  WAIT: rising edge of i_out_done (registered previous value) -> clear o_data
//   to 0, o_len stays until next first byte, -> IDLE. A done level already high
//   on WAIT entry does not count; a rising edge must occur.
//  Latency: finalizing event in cycle N -> PAD N+1 -> o_sha_start high in N+2.
//  o_data changes only in IDLE/COLLECT/PAD; stable from START through WAIT.
//  Any dv in PAD/START/WAIT -> byte discarded, o_drop=1 next cycle.
//  Unwritten block bytes are always 0 (cleared on WAIT exit and by reset).
//  o_len resets to 1 on the first byte of each new message.
//  Reset in any state, incl. mid-COLLECT or WAIT: immediate return to reset values;
//   partial message lost, no o_sha_start pulse.
// TESTING
//  1. Bytes 61 62 63 0D -> o_sha_start 2 cycles after 0D; o_data[511:480]=
//     32'h61626380, o_data[63:0]=64'h18, all other bits 0, o_len=3.
//  2. 55 bytes 0x41, no TERM -> auto-finalize; o_data[71:64]=8'h80,
//     o_data[63:0]=64'h1B8; a 56th byte in WAIT gives o_drop pulse, block unchanged.
//  3. IDLE_TIMEOUT=16: byte 0x5A then silence -> PAD after 16 idle cycles;
//     o_data[511:496]=16'h5A80, length 64'h8. Byte in expiry cycle -> no finalize.
//  4. 0D in IDLE -> no start, no drop, state IDLE; then "a" 0D -> normal block.
//  5. i_out_done held high entering WAIT -> stays WAIT; drop to 0 then 1 ->
//     IDLE, o_data=0; next message packs correctly.
//  6. rst mid-COLLECT after 2 bytes -> all outputs 0, no o_sha_start; new
//     message starts at index 0.

Source files
------------

// File: rtl/sha_msg_packer.sv
// Packs one UART message into a padded 512-bit SHA-256 block and hands it downstream.
// The block is held until the downstream done level rises, then cleared for the next message.
module sha_msg_packer #(
    parameter int          MAX_BYTES    = 55,
    parameter logic [7:0]  TERM_BYTE    = 8'h0D,
    parameter int          IDLE_TIMEOUT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_rx_dv,
    input  logic [7:0]   i_rx_byte,
    input  logic         i_out_done,
    output logic [511:0] o_data,
    output logic         o_sha_start,
    output logic         o_busy,
    output logic [5:0]   o_len,
    output logic         o_drop
);

    localparam int              TW       = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [TW-1:0]   TMO_LAST = (IDLE_TIMEOUT > 0) ? TW'(IDLE_TIMEOUT - 1) : '0;
    localparam logic [5:0]      LEN_LAST = 6'(MAX_BYTES - 1);

    typedef enum logic [2:0] {IDLE, COLLECT, PAD, START, WAIT} state_t;

    state_t state, nxt;

    // Byte i of the message lives in blk[63-i], i.e. blk[~i] for a 6-bit index.
    logic [63:0][7:0] blk;
    logic [TW-1:0]    timer;
    logic             done_q;

    logic store, first, pad, clr, tmr_clr, tmr_inc;
    logic is_term, busy;

    assign is_term     = (i_rx_byte == TERM_BYTE);
    assign busy        = (state == PAD) || (state == START) || (state == WAIT);
    assign o_busy      = busy;
    assign o_sha_start = (state == START);
    assign o_data      = blk;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt     = state;
        store   = 1'b0;
        first   = 1'b0;
        pad     = 1'b0;
        clr     = 1'b0;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;
        case (state)
            IDLE: begin
                // A bare terminator is an empty message and is silently ignored.
                if (i_rx_dv && !is_term) begin
                    store   = 1'b1;
                    first   = 1'b1;
                    tmr_clr = 1'b1;
                    nxt     = (MAX_BYTES == 1) ? PAD : COLLECT;
                end
            end
            COLLECT: begin
                if (i_rx_dv) begin
                    if (is_term) begin
                        nxt = PAD;
                    end else begin
                        store   = 1'b1;
                        tmr_clr = 1'b1;
                        if (o_len == LEN_LAST) nxt = PAD;
                    end
                end else if (IDLE_TIMEOUT > 0) begin
                    if (timer == TMO_LAST) nxt = PAD;
                    else                   tmr_inc = 1'b1;
                end
            end
            PAD: begin
                pad = 1'b1;
                nxt = START;
            end
            START: nxt = WAIT;
            WAIT: begin
                // Only a fresh rising edge releases the block; a stale high level does not.
                if (i_out_done && !done_q) begin
                    clr = 1'b1;
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk    <= '0;
            o_len  <= '0;
            timer  <= '0;
            done_q <= 1'b0;
            o_drop <= 1'b0;
        end else begin
            done_q <= i_out_done;
            o_drop <= i_rx_dv && busy;
            if (store) begin
                if (first) begin
                    blk[63] <= i_rx_byte;
                    o_len   <= 6'd1;
                end else begin
                    blk[~o_len] <= i_rx_byte;
                    o_len       <= o_len + 6'd1;
                end
            end
            if (pad) begin
                blk[~o_len] <= 8'h80;
                blk[7:0]    <= {55'd0, o_len, 3'd0};
            end
            if (clr) blk <= '0;
            if (tmr_clr)      timer <= '0;
            else if (tmr_inc) timer <= timer + 1'b1;
        end
    end

endmodule

// File: tb/tb_sha_msg_packer.sv
// Scoreboard bench for sha_msg_packer: a message-level model predicts each padded block,
// its start cycle and every discarded byte; a monitor compares whatever the DUT emits.
module tb_sha_msg_packer;

    logic         clk, rst, i_rx_dv, i_out_done;
    logic [7:0]   i_rx_byte;
    logic [511:0] o_data;
    logic         o_sha_start, o_busy, o_drop;
    logic [5:0]   o_len;

    sha_msg_packer #(.MAX_BYTES(55), .TERM_BYTE(8'h0D), .IDLE_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
        .i_out_done(i_out_done), .o_data(o_data), .o_sha_start(o_sha_start),
        .o_busy(o_busy), .o_len(o_len), .o_drop(o_drop)
    );

    typedef struct {
        logic [511:0] data;
        logic [5:0]   len;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    int           dq[$];
    logic [7:0]   msg[$];
    int           n_tests = 0, n_fail = 0;
    int           cyc = 0, starts = 0, s0 = 0;
    logic         holding = 1'b0;
    logic [511:0] held;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s at cycle %0d", nm, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT presents a start or a drop.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_sha_start) begin
                starts++;
                if (sbq.size() == 0) bad("unexpected_start");
                else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("blk_data", o_data, e.data);
                    chk("blk_len", 512'(o_len), 512'(e.len));
                    chk("start_cycle", 512'(cyc), 512'(e.cyc));
                end
                holding = 1'b1;
                held    = o_data;
            end else if (holding) begin
                if (o_busy) chk("blk_hold", o_data, held);
                else begin
                    holding = 1'b0;
                    chk("blk_clear", o_data, 512'd0);
                end
            end
            if (sbq.size() != 0 && sbq[0].cyc < cyc) begin
                void'(sbq.pop_front());
                bad("missed_start");
            end
            if (o_drop) begin
                if (dq.size() == 0) bad("unexpected_drop");
                else chk("drop_cycle", 512'(cyc), 512'(dq.pop_front()));
            end
            if (dq.size() != 0 && dq[0] < cyc) begin
                void'(dq.pop_front());
                bad("missed_drop");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, output int c);
        i_rx_dv   = 1'b1;
        i_rx_byte = b;
        c         = cyc;
        tick();
        i_rx_dv   = 1'b0;
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == 8'h0D) b = 8'h0E;
        return b;
    endfunction

    // Reference: block = message bytes, 0x80, zeros, 64-bit bit length; start two
    // cycles after the finalizing event (terminator, 55th byte, or 16th idle cycle).
    task automatic send_msg(input int gmax, input bit use_term, input bit drop_extra);
        exp_t e;
        int   n, c, last;
        n      = msg.size();
        s0     = starts;
        e.data = '0;
        for (int i = 0; i < n; i++) e.data[511-8*i -: 8] = msg[i];
        e.data[511-8*n -: 8] = 8'h80;
        e.data[63:0]         = 64'(n * 8);
        e.len                = 6'(n);
        last                 = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) idle($urandom_range(0, gmax));
            send_byte(msg[i], last);
        end
        if (n == 55) begin
            e.cyc = last + 2;
            sbq.push_back(e);
            if (drop_extra) begin
                send_byte(8'h41, c);
                dq.push_back(c + 1);
            end
        end else if (use_term) begin
            idle($urandom_range(0, gmax));
            send_byte(8'h0D, c);
            e.cyc = c + 2;
            sbq.push_back(e);
        end else begin
            e.cyc = last + 16 + 2;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_start();
        int k = 0;
        while (starts == s0 && k < 60) begin
            tick();
            k++;
        end
        if (starts == s0) bad("start_timeout");
    endtask

    task automatic finish_blk(input int ndrop, input int n);
        int c;
        idle($urandom_range(0, 3));
        for (int i = 0; i < ndrop; i++) begin
            send_byte(rnd_byte(), c);
            dq.push_back(c + 1);
        end
        i_out_done = 1'b1;
        tick();
        chk("exit_busy", 512'(o_busy), 512'd0);
        chk("exit_data", o_data, 512'd0);
        chk("exit_len", 512'(o_len), 512'(n));
        idle($urandom_range(0, 2));
        i_out_done = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c, n;
        rst = 1'b1; i_rx_dv = 1'b0; i_rx_byte = 8'h00; i_out_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_data", o_data, 512'd0);
        chk("rst_len", 512'(o_len), 512'd0);
        chk("rst_ctl", 512'({o_sha_start, o_busy, o_drop}), 512'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // "abc" + terminator
        msg = {8'h61, 8'h62, 8'h63};
        send_msg(0, 1'b1, 1'b0);
        wait_start();
        finish_blk(0, 3);

        // 55 bytes auto-finalize, extra byte dropped while the block is busy
        msg.delete();
        for (int i = 0; i < 55; i++) msg.push_back(8'h41);
        send_msg(1, 1'b0, 1'b1);
        wait_start();
        finish_blk(1, 55);

        // idle timeout, then a byte landing exactly in the expiry cycle
        msg = {8'h5A};
        send_msg(0, 1'b0, 1'b0);
        wait_start();
        finish_blk(0, 1);
        msg = {8'h5A, 8'h5B};
        s0  = starts;
        begin
            exp_t e;
            int   b0;
            e.data = '0;
            e.data[511:488] = 24'h5A5B80;
            e.data[63:0]    = 64'h10;
            e.len           = 6'd2;
            send_byte(8'h5A, b0);
            idle(15);
            send_byte(8'h5B, c);
            e.cyc = c + 18;
            sbq.push_back(e);
        end
        wait_start();
        finish_blk(0, 2);

        // bare terminator in IDLE is ignored
        send_byte(8'h0D, c);
        idle(4);
        chk("term_idle_busy", 512'(o_busy), 512'd0);
        msg = {8'h61};
        send_msg(0, 1'b1, 1'b0);
        wait_start();
        finish_blk(0, 1);

        // done level already high on WAIT entry must not release the block
        i_out_done = 1'b1;
        msg = {8'h68, 8'h69};
        send_msg(2, 1'b1, 1'b0);
        wait_start();
        idle(5);
        chk("stale_done_busy", 512'(o_busy), 512'd1);
        i_out_done = 1'b0;
        idle(2);
        finish_blk(0, 2);

        // reset mid-message discards it; the next message starts at index 0
        send_byte(8'h31, c);
        send_byte(8'h32, c);
        rst = 1'b1;
        idle(2);
        chk("midrst_data", o_data, 512'd0);
        chk("midrst_len", 512'(o_len), 512'd0);
        chk("midrst_busy", 512'(o_busy), 512'd0);
        rst = 1'b0;
        tick();
        msg = {8'h33, 8'h34, 8'h35, 8'h36};
        send_msg(0, 1'b1, 1'b0);
        wait_start();
        finish_blk(0, 4);

        // randomized messages
        for (int t = 0; t < 14; t++) begin
            n = $urandom_range(1, 55);
            msg.delete();
            for (int i = 0; i < n; i++) msg.push_back(rnd_byte());
            send_msg(($urandom_range(0, 3) == 0) ? 15 : 3, 1'($urandom_range(0, 1)), 1'b1);
            wait_start();
            finish_blk($urandom_range(0, 2), n);
        end

        idle(4);
        chk("sb_empty", 512'(sbq.size()), 512'd0);
        chk("drop_q_empty", 512'(dq.size()), 512'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
